// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Fetch-stage front end with one outstanding imem request, a
//               stall-holding instruction buffer and redirect kill handling.
//               Optional perf counters enabled by `define FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   F_stall_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_ready_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]    F_PC_o,
    output logic                   fetch_wait_o,
    output logic [31:0]            perf_fetched_o,
    output logic [31:0]            perf_wait_o
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] c_PC_STEP = PC_WIDTH'(4);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    w_pc_nxt;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [INSTR_WIDTH-1:0] w_instr_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   w_consume;
    logic [PC_WIDTH-1:0]    w_redirect_pc;
    logic                   w_unused_ok;

    assign w_redirect_pc = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    assign w_unused_ok   = &{1'b0, redirect_pc_i[1:0]};
    assign w_consume     = (r_state == S_HOLD) & ~F_stall_i & ~redirect_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        if (redirect_i) begin
            w_pc_nxt    = w_redirect_pc;
            w_valid_nxt = 1'b0;
            // Any request already accepted must have its response drained.
            // A response arriving in the redirect cycle itself closes it out.
            case (r_state)
                S_REQ:   w_state_nxt = imem_ready_i  ? S_DRAIN : S_REQ;
                S_WAIT:  w_state_nxt = imem_rvalid_i ? S_REQ   : S_DRAIN;
                S_HOLD:  w_state_nxt = S_REQ;
                S_DRAIN: w_state_nxt = imem_rvalid_i ? S_REQ   : S_DRAIN;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ready_i) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        w_instr_nxt = imem_rdata_i;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_consume) begin
                        w_pc_nxt    = r_pc + c_PC_STEP;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid_i) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    assign imem_req_o   = (r_state == S_REQ) & ~rst_i;
    assign imem_addr_o  = r_pc;
    assign instr_o      = r_valid ? r_instr : '0;
    assign F_PC_o       = r_valid ? r_pc : '0;
    assign fetch_wait_o = ~r_valid;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_wait;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_fetched <= '0;
            r_perf_wait    <= '0;
        end else begin
            if (w_consume) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!r_valid) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_wait_o    = r_perf_wait;
`else
    assign perf_fetched_o = '0;
    assign perf_wait_o    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed vector table,
//               hand-written redirect/reset sequences and a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        rv;
    logic [31:0] rdat;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] instr_o;
    logic [31:0] F_PC_o;
    logic        fetch_wait_o;
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_wait_o;

    int tests  = 0;
    int failed = 0;

    fetch_unit #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .RESET_PC    (32'h0000_0100)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .F_stall_i      (stall),
        .redirect_i     (redir),
        .redirect_pc_i  (rpc),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ready_i   (rdy),
        .imem_rvalid_i  (rv),
        .imem_rdata_i   (rdat),
        .instr_o        (instr_o),
        .F_PC_o         (F_PC_o),
        .fetch_wait_o   (fetch_wait_o),
        .perf_fetched_o (perf_fetched_o),
        .perf_wait_o    (perf_wait_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wt;
    } vec_t;

    vec_t tbl [10];

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] rp,
                         input logic rdy_v, input logic rv_v, input logic [31:0] dat);
        @(negedge clk);
        rst = r; stall = st; redir = rd; rpc = rp; rdy = rdy_v; rv = rv_v; rdat = dat;
        #1;
    endtask

    task automatic expo(input string nm, input logic req, input logic [31:0] addr,
                        input logic [31:0] instr, input logic [31:0] pc, input logic wt);
        tests++;
        if ({imem_req_o, imem_addr_o, instr_o, F_PC_o, fetch_wait_o} !== {req, addr, instr, pc, wt}) begin
            failed++;
            $display("FAIL %s: got req=%0b addr=%h instr=%h pc=%h wait=%0b, want req=%0b addr=%h instr=%h pc=%h wait=%0b",
                     nm, imem_req_o, imem_addr_o, instr_o, F_PC_o, fetch_wait_o, req, addr, instr, pc, wt);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            failed++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Reference model: pending/killed response bookkeeping plus an instruction buffer.
    logic        m_valid, m_out, m_kill;
    logic [31:0] m_pc, m_instr;
    int          m_fetched, m_wait;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_data;

    initial begin
        rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = '0; rdy = 1'b0; rv = 1'b0; rdat = '0;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h100, 32'h0,         32'h0,   1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h1111_0001, 1'b0, 32'h100, 32'h0,         32'h0,   1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h100, 32'h1111_0001, 32'h100, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h104, 32'h0,         32'h0,   1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h2222_0002, 1'b0, 32'h104, 32'h0,         32'h0,   1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h104, 32'h2222_0002, 32'h104, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h108, 32'h0,         32'h0,   1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h3333_0003, 1'b0, 32'h108, 32'h0,         32'h0,   1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h108, 32'h3333_0003, 32'h108, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10C, 32'h0,         32'h0,   1'b1};

        // Reset state
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expo("reset", 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        chk32("reset_perf_fetched", perf_fetched_o, 32'h0);
        chk32("reset_perf_wait", perf_wait_o, 32'h0);

        // Back-to-back deliveries, one every three cycles
        for (int i = 0; i < 10; i++) begin
            drive(0, tbl[i].stall, 0, 0, tbl[i].ready, tbl[i].rvalid, tbl[i].rdata);
            expo($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].instr, tbl[i].pc, tbl[i].wt);
        end
        chk32("perf_fetched_3", perf_fetched_o, c_PERF ? 32'd3 : 32'd0);
        chk32("perf_wait_6", perf_wait_o, c_PERF ? 32'd6 : 32'd0);

        // Stall holds the buffered instruction
        drive(0, 0, 0, 0, 1, 0, 0);
        expo("t2_req", 1, 32'h10C, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 32'h4444_0004);
        expo("t2_wait", 0, 32'h10C, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            expo("t2_hold", 0, 32'h10C, 32'h4444_0004, 32'h10C, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        expo("t2_release", 0, 32'h10C, 32'h4444_0004, 32'h10C, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expo("t2_next", 1, 32'h110, 0, 0, 1);

        // Redirect during wait: in-flight response drained
        drive(0, 0, 0, 0, 1, 0, 0);
        expo("t3_req", 1, 32'h110, 0, 0, 1);
        drive(0, 0, 1, 32'h203, 0, 0, 0);
        expo("t3_wait", 0, 32'h110, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        expo("t3_drain", 0, 32'h200, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD_DEAD);
        expo("t3_drain2", 0, 32'h200, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        expo("t3_after", 1, 32'h200, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        expo("t3_nodata", 1, 32'h200, 0, 0, 1);

        // Redirect coinciding with response
        drive(0, 0, 0, 0, 1, 0, 0);
        expo("t4_req", 1, 32'h200, 0, 0, 1);
        drive(0, 0, 1, 32'h300, 0, 1, 32'hBEEF_BEEF);
        expo("t4_wait", 0, 32'h200, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        expo("t4_redir", 1, 32'h300, 0, 0, 1);

        // PC wrap, then reset while waiting with a late response
        drive(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        expo("t5_req", 1, 32'h300, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 0);
        expo("t5_top", 1, 32'hFFFF_FFFC, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 32'h5555_0005);
        expo("t5_topwait", 0, 32'hFFFF_FFFC, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        expo("t5_hold", 0, 32'hFFFF_FFFC, 32'h5555_0005, 32'hFFFF_FFFC, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        expo("t5_wrap", 1, 32'h0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        expo("t5_wait", 0, 32'h0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 32'h6666_0006);
        expo("t5_rst", 1, 32'h100, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        expo("t5_late", 1, 32'h100, 0, 0, 1);

        // Randomized run against the reference model
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        m_valid = 0; m_out = 0; m_kill = 0; m_pc = 32'h100; m_instr = 0;
        m_fetched = 0; m_wait = 0;
        mem_busy = 0; mem_cnt = 0; mem_data = 0;
        for (int i = 0; i < 3000; i++) begin
            logic st_v, rd_v, rdy_v, rv_v, req_exp;
            logic [31:0] rp_v, dat_v;
            st_v  = ($urandom % 10) < 4;
            rd_v  = ($urandom % 12) == 0;
            rp_v  = $urandom;
            rdy_v = ($urandom % 3) != 0;
            dat_v = $urandom;
            if (mem_busy && mem_cnt == 0) begin
                rv_v = 1; dat_v = mem_data;
            end else if (!mem_busy && ($urandom % 16) == 0) begin
                rv_v = 1;
            end else begin
                rv_v = 0;
            end
            drive(0, st_v, rd_v, rp_v, rdy_v, rv_v, dat_v);
            req_exp = !m_valid && !m_out;
            expo("rand", req_exp, m_pc, m_valid ? m_instr : 32'h0, m_valid ? m_pc : 32'h0, !m_valid);

            if (!m_valid) m_wait++;
            if (rd_v) begin
                m_pc = {rp_v[31:2], 2'b00};
                m_valid = 0;
                if (req_exp && rdy_v) begin
                    m_out = 1; m_kill = 1;
                end else if (m_out && rv_v) begin
                    m_out = 0; m_kill = 0;
                end else if (m_out) begin
                    m_kill = 1;
                end
            end else if (req_exp && rdy_v) begin
                m_out = 1; m_kill = 0;
            end else if (m_out && rv_v) begin
                if (!m_kill) begin
                    m_instr = dat_v; m_valid = 1;
                end
                m_out = 0; m_kill = 0;
            end else if (m_valid && !st_v) begin
                m_pc = m_pc + 32'd4;
                m_valid = 0;
                m_fetched++;
            end

            if (mem_busy && rv_v) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (imem_req_o && rdy_v) begin
                mem_busy = 1;
                mem_cnt  = $urandom_range(0, 2);
                mem_data = $urandom;
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk32("rand_perf_fetched", perf_fetched_o, c_PERF ? 32'(m_fetched) : 32'd0);
        chk32("rand_perf_wait", perf_wait_o, c_PERF ? 32'(m_wait) : 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
